regfile_sb: RTL
===============

# regfile_sb

Parametrised multi-port register file with a per-register busy scoreboard, for the CPU datapath. It provides two combinational read ports with same-cycle write bypass and one synchronous write port. A reserve port marks a destination register as pending until its writeback arrives. Read ports report a valid flag, so issue logic can stall on pending operands. It replaces the fixed 16-bit, 4-entry file and adds reset, out-of-range handling and hazard tracking.

## Interface
Parameters:
- DATA_W, 16, width of each register and data port
- NREGS, 8, number of registers (2..2**ADDR_W)
- ADDR_W, 3, width of all address ports
- ZERO_REG, 0, when 1: r0 always reads 0, writes to r0 are dropped, reserves of r0 are refused

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- write  in  1  write enable
- wr_Addr  in  ADDR_W  write address
- wr_Data  in  DATA_W  write data
- rd_AddrA  in  ADDR_W  read port A address
- rd_DataA  out  DATA_W  read port A data (combinational)
- rd_ValidA  out  1  port A operand not pending
- rd_AddrB  in  ADDR_W  read port B address
- rd_DataB  out  DATA_W  read port B data (combinational)
- rd_ValidB  out  1  port B operand not pending
- rsv  in  1  reserve request (destination issued)
- rsv_Addr  in  ADDR_W  register to reserve
- rsv_ok  out  1  reserve accepted this cycle (combinational)
- busy  out  NREGS  scoreboard vector, bit i = register i pending

## Operation
- Storage: NREGS x DATA_W registers plus an NREGS-bit busy vector.
- Reset (rst=1, asynchronous): all registers become 0 and busy becomes 0 immediately, without waiting for a clock edge.
  - During reset, rd_Data* reflects 0 unless bypassed by the current write.
  - rd_Valid* = 1 and rsv_ok = rsv for in-range addresses.
- Write: on the edge with write=1 and wr_Addr < NREGS (and not r0 when ZERO_REG=1), the register takes wr_Data and its busy bit clears.
  - Out-of-range writes are ignored entirely.
- Read, per port X in {A, B}:
  - Out of range, or r0 with ZERO_REG=1: data = 0, valid = 1.
  - Else if write=1 and wr_Addr == rd_AddrX (writable): data = wr_Data, valid = 1 (bypass).
  - Else: data = stored value, valid = !busy[rd_AddrX].
- Reserve: rsv_ok = rsv and address in range and not (ZERO_REG and address 0) and (busy[rsv_Addr]=0 or a write to rsv_Addr is present this cycle).
  - On the edge with rsv_ok=1, busy[rsv_Addr] is set.
  - A refused reserve changes no state; the requester holds rsv and retries.
- Simultaneous write and reserve to the same address: data is written and busy ends at 1 (the reserve wins).
- Writes to a non-busy register are legal: data is updated and busy stays 0.
- Both read ports may address the same register or the write address; each resolves independently.

## Timing
- Read latency 0: data and valid are combinational from addresses, write inputs and stored state.
- Write latency 1 edge to storage; the bypass gives the same-cycle view.
- Busy set/clear takes effect at the edge; the busy output is registered.
- rsv_ok has no register; it depends on busy and the same-cycle write.
- Reset assertion mid-cycle wipes pending reservations and data. The first edge after deassertion behaves normally.

## Test plan
- Reset with defaults: assert rst, read all 8 addresses -> every rd_Data = 0x0000, rd_Valid = 1, busy = 8'h00.
- Write r3=0xBEEF, next cycle read A=3 and B=3 -> both 0xBEEF, valid 1. In the write cycle itself, A=3 also shows 0xBEEF via bypass.
- Scoreboard:
  - rsv r5 -> rsv_ok=1, busy=8'h20, A=5 valid 0.
  - A second rsv r5 -> rsv_ok=0.
  - write r5=0x1234 -> same cycle A=5 gives 0x1234 valid 1; next cycle busy=8'h00.
- Write r2=0x0042 and rsv r2 in the same cycle, with r2 busy beforehand -> rsv_ok=1, stored 0x0042, busy[2] stays 1, next-cycle read valid 0.
- ZERO_REG=1, NREGS=6, ADDR_W=3:
  - write r0=0xFFFF then read r0 -> 0x0000 valid 1.
  - rsv r0 -> rsv_ok=0.
  - write r7 -> no change; read r7 -> 0 valid 1.
- Reserve r1 and r4 (busy=8'h12), then pulse rst between edges -> busy=8'h00 immediately, all data 0, rsv r1 accepted next cycle.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-port register file: two combinational read ports with write bypass,
// one synchronous write port, and a per-register busy scoreboard for issue stalls.
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int NREGS    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [ADDR_W-1:0] wr_Addr,
    input  logic [DATA_W-1:0] wr_Data,
    input  logic [ADDR_W-1:0] rd_AddrA,
    output logic [DATA_W-1:0] rd_DataA,
    output logic              rd_ValidA,
    input  logic [ADDR_W-1:0] rd_AddrB,
    output logic [DATA_W-1:0] rd_DataB,
    output logic              rd_ValidB,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_Addr,
    output logic              rsv_ok,
    output logic [NREGS-1:0]  busy
);

    localparam int              NSLOT   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] NREGS_W = (ADDR_W + 1)'(NREGS);

    logic [DATA_W-1:0] mem_reg [NREGS];
    logic [NREGS-1:0]  busy_reg;
    logic [NREGS-1:0]  busy_next;

    // Full address-space views so every address indexes a defined slot.
    logic [DATA_W-1:0] slot_data [NSLOT];
    logic [NSLOT-1:0]  slot_busy;

    logic              wr_en;
    logic              rsv_hit_wr;

    logic [ADDR_W-1:0] rd_addr  [2];
    logic [DATA_W-1:0] rd_data  [2];
    logic              rd_valid [2];

    // An address is "writable" when it maps to real, non-hardwired storage.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, a} < NREGS_W);
        is_zero  = (ZERO_REG != 0) && (a == '0);
        return in_range && !is_zero;
    endfunction

    assign wr_en      = write && writable(wr_Addr);
    assign rsv_hit_wr = wr_en && (wr_Addr == rsv_Addr);
    assign rsv_ok     = rsv && writable(rsv_Addr) && (!slot_busy[rsv_Addr] || rsv_hit_wr);
    assign busy       = busy_reg;

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NREGS) begin : g_real
                assign slot_data[gi] = mem_reg[gi];
                assign slot_busy[gi] = busy_reg[gi];
            end else begin : g_void
                assign slot_data[gi] = '0;
                assign slot_busy[gi] = 1'b0;
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            // Reserve has priority over writeback clearing the same bit.
            always_comb begin
                busy_next[gi] = busy_reg[gi];
                if (rsv_ok && (rsv_Addr == ADDR_W'(gi))) begin
                    busy_next[gi] = 1'b1;
                end else if (wr_en && (wr_Addr == ADDR_W'(gi))) begin
                    busy_next[gi] = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi]  <= '0;
                    busy_reg[gi] <= 1'b0;
                end else begin
                    busy_reg[gi] <= busy_next[gi];
                    if (wr_en && (wr_Addr == ADDR_W'(gi))) begin
                        mem_reg[gi] <= wr_Data;
                    end
                end
            end
        end
    endgenerate

    assign rd_addr[0] = rd_AddrA;
    assign rd_addr[1] = rd_AddrB;
    assign rd_DataA   = rd_data[0];
    assign rd_ValidA  = rd_valid[0];
    assign rd_DataB   = rd_data[1];
    assign rd_ValidB  = rd_valid[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rd_data[gi]  = '0;
                rd_valid[gi] = 1'b1;
                if (!writable(rd_addr[gi])) begin
                    rd_data[gi]  = '0;
                    rd_valid[gi] = 1'b1;
                end else if (wr_en && (wr_Addr == rd_addr[gi])) begin
                    rd_data[gi]  = wr_Data;
                    rd_valid[gi] = 1'b1;
                end else begin
                    rd_data[gi]  = slot_data[rd_addr[gi]];
                    rd_valid[gi] = !slot_busy[rd_addr[gi]];
                end
            end
        end
    endgenerate

endmodule
